// File: rtl/io_unit.sv
// io_unit -- character I/O port for the accumulator CPU.
//
// Holds the input register INPR, the output register OUTR, the flags FGI/FGO,
// the interrupt enable IEN and a registered interrupt request. The control
// unit drives INP/OUT/ION/IOF pulses and the interrupt-cycle acknowledge.
// External devices use valid/ready byte handshakes on both sides.
//
// Optional build macro: IO_RX_FIFO_EN
//   When it is defined, an RX_DEPTH-entry receive FIFO replaces the single
//   INPR register. FGI then means "FIFO not empty", o_inpr shows the FIFO
//   head, and INP pops one entry.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   i_inp / o_inpr        INP pulse (clears FGI or pops), current INPR value
//   i_out / i_ac          OUT pulse, AC low bits latched into OUTR
//   i_ion/i_iof/i_int_ack set / clear / clear of IEN (a clear wins)
//   o_fgi, o_fgo, o_ien   flags for SKI/SKO and interrupt enable
//   o_irq                 registered IEN & (FGI | FGO)
//   o_tx_drop             sticky: an OUT was ignored because FGO was 0
//   i_rx_*/o_rx_ready     receive handshake from the device
//   o_tx_*/i_tx_ready     transmit handshake toward the device
module io_unit #(
  parameter int CWIDTH   = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_inp,
  output logic [CWIDTH-1:0] o_inpr,
  input  logic              i_out,
  input  logic [CWIDTH-1:0] i_ac,
  input  logic              i_ion,
  input  logic              i_iof,
  input  logic              i_int_ack,
  output logic              o_fgi,
  output logic              o_fgo,
  output logic              o_ien,
  output logic              o_irq,
  output logic              o_tx_drop,
  input  logic [CWIDTH-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [CWIDTH-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready
);

  // The FIFO build relies on natural pointer wrap, so the depth must be a
  // power of two and at least 2.
  if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("io_unit: RX_DEPTH must be a power of two and at least 2");
  end

  logic              fgi;
  logic              fgo;
  logic              ien;
  logic              irq;
  logic              tx_valid;
  logic              tx_drop;
  logic [CWIDTH-1:0] outr;
  logic              rx_push;
  logic              rx_pop;
  logic              tx_done;

  assign rx_push = i_rx_valid & o_rx_ready;
  assign rx_pop  = i_inp & fgi;
  assign tx_done = tx_valid & i_tx_ready;

`ifdef IO_RX_FIFO_EN
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

  logic [CWIDTH-1:0] mem [RX_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (rx_push) wptr <= wptr + 1'b1;
      if (rx_pop)  rptr <= rptr + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({rx_push, rx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (rx_push) mem[wptr] <= i_rx_data;
  end

  assign fgi        = (count != '0);
  assign o_rx_ready = (count != FULL_CNT);
  assign o_inpr     = mem[rptr];
`else
  logic [CWIDTH-1:0] inpr;

  // Ready is ~FGI, so a new character and an INP pop can never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inpr <= '0;
      fgi  <= 1'b0;
    end else if (rx_push) begin
      inpr <= i_rx_data;
      fgi  <= 1'b1;
    end else if (rx_pop) begin
      fgi  <= 1'b0;
    end
  end

  assign o_rx_ready = ~fgi;
  assign o_inpr     = inpr;
`endif

  // FGO=1 implies no transfer in flight, so a load and a device accept are
  // mutually exclusive. An OUT while FGO=0 (including the accept cycle) is
  // dropped and recorded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outr     <= '0;
      fgo      <= 1'b1;
      tx_valid <= 1'b0;
      tx_drop  <= 1'b0;
    end else begin
      if (i_out && fgo) begin
        outr     <= i_ac;
        fgo      <= 1'b0;
        tx_valid <= 1'b1;
      end else if (tx_done) begin
        tx_valid <= 1'b0;
        fgo      <= 1'b1;
      end
      if (i_out && !fgo) tx_drop <= 1'b1;
    end
  end

  // IRQ is built from the current register values, so it trails any flag or
  // IEN change by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ien <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (i_iof || i_int_ack) ien <= 1'b0;
      else if (i_ion)         ien <= 1'b1;
      irq <= ien & (fgi | fgo);
    end
  end

  assign o_fgi      = fgi;
  assign o_fgo      = fgo;
  assign o_ien      = ien;
  assign o_irq      = irq;
  assign o_tx_drop  = tx_drop;
  assign o_tx_data  = outr;
  assign o_tx_valid = tx_valid;

endmodule

// File: doc/io_unit.md
Name: io_unit

Overview:
- Character I/O port on the CPU's I/O side: input register INPR, output register OUTR, flags FGI/FGO, interrupt enable IEN, interrupt request.
- Executed by the control unit's INP/OUT/SKI/SKO/ION/IOF instructions and the interrupt-cycle entry.
- Toward external devices: valid/ready byte handshakes on the receive and transmit sides.

Parameters:
- CWIDTH, 8, character width of INPR/OUTR and the device data paths.
- RX_DEPTH, 4, receive FIFO depth, power of 2 and at least 2; used only with IO_RX_FIFO_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- i_inp  input  1  INP execute pulse: CPU reads o_inpr this cycle; clears FGI
- o_inpr  output  CWIDTH  current INPR value, loaded into AC low bits by the datapath
- i_out  input  1  OUT execute pulse: latch i_ac into OUTR
- i_ac  input  CWIDTH  AC low bits
- i_ion  input  1  ION pulse: set IEN
- i_iof  input  1  IOF pulse: clear IEN
- i_int_ack  input  1  CPU entering interrupt cycle: clear IEN
- o_fgi  output  1  input flag, for SKI
- o_fgo  output  1  output flag, for SKO
- o_ien  output  1  interrupt enable
- o_irq  output  1  registered interrupt request
- o_tx_drop  output  1  sticky: an OUT arrived while FGO=0
- i_rx_data  input  CWIDTH  device receive data
- i_rx_valid  input  1  device receive data valid
- o_rx_ready  output  1  unit can accept a character
- o_tx_data  output  CWIDTH  transmit data, equal to OUTR
- o_tx_valid  output  1  transmit data valid
- i_tx_ready  input  1  device accepts the transmit character

Behaviour:
- Reset (async, reset_n=0): INPR=0, OUTR=0, FGI=0, FGO=1, IEN=0, o_irq=0, o_tx_valid=0, o_tx_drop=0. o_rx_ready therefore reads 1.
- Single clock domain. All state updates on the rising clk edge.
- Receive path:
  - o_rx_ready = ~FGI (combinational).
  - Handshake i_rx_valid & o_rx_ready: INPR<=i_rx_data and FGI<=1 on the next edge.
  - i_inp with FGI=1: o_inpr is valid that cycle; FGI<=0 on the next edge.
  - i_inp with FGI=0: o_inpr shows stale INPR; no state change.
  - A handshake and an i_inp in the same cycle cannot both take effect, because ready is 0 whenever FGI=1.
- Transmit path:
  - i_out with FGO=1: OUTR<=i_ac, FGO<=0, o_tx_valid<=1.
  - o_tx_data stays stable while o_tx_valid=1.
  - i_tx_valid & i_tx_ready: o_tx_valid<=0, FGO<=1 on the same edge.
  - i_out with FGO=0: OUTR and the transfer in flight are unchanged; o_tx_drop<=1. o_tx_drop is cleared only by reset.
  - i_out arriving in the same cycle the device accepts: FGO is still 0 in that cycle, so the OUT is dropped as above.
- Interrupt enable, next IEN:
  - 0 if i_iof or i_int_ack.
  - else 1 if i_ion.
  - else hold.
  - Clear wins over set.
- Interrupt request: o_irq <= IEN & (FGI | FGO), evaluated on current register values. o_irq lags a flag or IEN change by exactly 1 cycle.
- Reset mid-transfer: the pending transmit is abandoned (o_tx_valid=0 immediately). A receive in flight is lost.

Optional Feature:
- Macro IO_RX_FIFO_EN. When defined, a RX_DEPTH-entry receive FIFO replaces the single INPR register:
  - o_rx_ready = FIFO not full.
  - FGI = FIFO not empty.
  - o_inpr = FIFO head.
  - i_inp with FGI=1 pops one entry.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - A push while full is impossible, since ready=0.
  - Read/write pointers wrap modulo RX_DEPTH.
  - Reset empties the FIFO.
- When not defined: single-register behaviour as above, and RX_DEPTH is unused.

Test Plan:
- Reset check: after reset, o_fgi=0, o_fgo=1, o_rx_ready=1, o_tx_valid=0, o_ien=0, o_irq=0, o_tx_drop=0.
- Receive: rx_data=8'h41 with valid for 1 cycle -> next cycle o_fgi=1, o_inpr=8'h41, o_rx_ready=0; i_inp pulse -> o_fgi=0 and o_rx_ready=1 one cycle later.
- Transmit with stall: i_ac=8'h5A, i_out pulse -> o_tx_valid=1, o_tx_data=8'h5A, o_fgo=0. Hold i_tx_ready=0 for 3 cycles -> data stable. i_tx_ready=1 -> o_tx_valid=0 and o_fgo=1 next cycle.
- Drop: i_out with i_ac=8'h11 while transmitting 8'h5A -> o_tx_data stays 8'h5A, o_tx_drop=1 and stays 1 until reset.
- Interrupt:
  - i_ion with FGO=1 -> o_ien=1 next cycle, o_irq=1 one cycle after that.
  - i_ion and i_int_ack in the same cycle -> o_ien=0.
  - i_int_ack -> o_ien=0, and o_irq=0 one cycle later.
- IO_RX_FIFO_EN with RX_DEPTH=4:
  - Push 8'h01..8'h04 -> o_rx_ready=0.
  - Pop with simultaneous push of 8'h05 when 3 entries are held -> count stays 3.
  - Pop sequence returns data in order and pointers wrap correctly.
